// File: rtl/mem_port_arbiter.sv
// Byte-memory port arbiter: data (load/store) beats fetch; each word is moved as 4 big-endian byte accesses.
// Latency: 6 cycles from the IDLE grant cycle to the ack pulse; a halted fetch (or trapped misaligned access) acks in 1.
// Backpressure: requesters hold req until their ack; requests are ignored outside IDLE, captured operands are frozen.
//
// Ports:
//   mem_Clk / mem_Rst_n              clock, asynchronous active-low reset
//   instr_en/req/addr -> ack/data    fetch port (HALT_WORD returned while instr_en is low)
//   data_rd/wr/addr/wdata -> ack/rdata  load/store port (rd+wr together acts as a store)
//   mem_addr/re/we/wdata <- mem_rdata  byte memory master port, 1-cycle read latency
//   busy                             high whenever the FSM is not IDLE
// Optional feature macro: MISALIGN_TRAP_EN adds misalign_err and rejects addr[1:0] != 0
// without touching memory.
module mem_port_arbiter #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              mem_Clk,
  input  logic              mem_Rst_n,
  input  logic              instr_en,
  input  logic              instr_req,
  input  logic [31:0]       instr_addr,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic              data_rd,
  input  logic              data_wr,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ack,
  output logic [31:0]       data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic              own_data;   // 1: load/store unit owns the transfer, 0: fetch
  logic              op_wr;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wbuf;
  logic [23:0]       rd_shift;   // bytes 0..2 of a read, oldest in the top byte

  // Grant decode, only acted on in IDLE.
  logic        req_data;
  logic        req_fetch;
  logic        halt_fetch;
  logic        misalign;
  logic [31:0] sel_addr;

  assign req_data   = data_rd | data_wr;
  assign req_fetch  = instr_req & ~req_data;
  assign halt_fetch = req_fetch & ~instr_en;
  assign sel_addr   = req_data ? data_addr : instr_addr;

`ifdef MISALIGN_TRAP_EN
  // A halted fetch never touches memory, so it is never reported as misaligned.
  assign misalign = (req_data | (req_fetch & instr_en)) & (sel_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Request address bits above the memory width are deliberately dropped.
  generate
    if (ADDR_W < 32) begin : g_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^{instr_addr[31:ADDR_W], data_addr[31:ADDR_W]};
    end
  endgenerate

  assign busy = (state != ST_IDLE);

  always_ff @(posedge mem_Clk or negedge mem_Rst_n) begin
    if (!mem_Rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 2'd0;
      own_data   <= 1'b0;
      op_wr      <= 1'b0;
      base       <= '0;
      wbuf       <= '0;
      rd_shift   <= '0;
      instr_ack  <= 1'b0;
      instr_data <= '0;
      data_ack   <= 1'b0;
      data_rdata <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      // Acks are single-cycle pulses raised only on the transition into ACK.
      instr_ack <= 1'b0;
      data_ack  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= 2'd0;
          if (req_data || instr_req) begin
            own_data <= req_data;
            op_wr    <= data_wr & req_data;
            base     <= sel_addr[ADDR_W-1:0];
            wbuf     <= data_wdata;
            if (halt_fetch || misalign) begin
              // No memory access: go straight to ACK with the substitute result.
              state <= ST_ACK;
              if (req_data) begin
                data_ack <= 1'b1;
                if (!data_wr) data_rdata <= '0;
              end else begin
                instr_ack  <= 1'b1;
                instr_data <= halt_fetch ? HALT_WORD : 32'h0;
              end
`ifdef MISALIGN_TRAP_EN
              misalign_err <= misalign;
`endif
            end else begin
              // Byte 0 strobe is presented in the first XFER cycle.
              state     <= ST_XFER;
              mem_addr  <= sel_addr[ADDR_W-1:0];
              mem_re    <= ~(req_data & data_wr);
              mem_we    <= req_data & data_wr;
              mem_wdata <= data_wdata[31:24];
            end
          end
        end

        ST_XFER: begin
          // Read data for the previous cycle's strobe arrives now.
          if (!op_wr && cnt != 2'd0) rd_shift <= {rd_shift[15:0], mem_rdata};
          if (cnt == 2'd3) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            state  <= ST_LAST;
          end else begin
            cnt      <= cnt + 2'd1;
            // Natural ADDR_W-bit wrap at the top of memory.
            mem_addr <= base + ADDR_W'(cnt) + ADDR_W'(1);
            case (cnt)
              2'd0:    mem_wdata <= wbuf[23:16];
              2'd1:    mem_wdata <= wbuf[15:8];
              default: mem_wdata <= wbuf[7:0];
            endcase
          end
        end

        ST_LAST: begin
          // Byte 3 arrives here; writes idle through this cycle for uniform latency.
          state <= ST_ACK;
          cnt   <= 2'd0;
          if (own_data) begin
            data_ack <= 1'b1;
            if (!op_wr) data_rdata <= {rd_shift, mem_rdata};
          end else begin
            instr_ack  <= 1'b1;
            instr_data <= {rd_shift, mem_rdata};
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int OP_FETCH = 0;
  localparam int OP_HALT  = 1;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;
  localparam int OP_RW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_en = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic        data_rd = 1'b0;
  logic        data_wr = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        busy;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .HALT_WORD(32'hFFFFFFFF)) dut (
    .mem_Clk(clk), .mem_Rst_n(rst_n),
    .instr_en(instr_en), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data),
    .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .busy(busy)
  );

  // Byte memory model: 1-cycle read latency, write at the rising edge.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  // Strobe monitor.
  int          n_strobe = 0;
  int          n_strobe_viol = 0;
  logic [15:0] addr_trace [$];
  always @(negedge clk) begin
    if (mem_re || mem_we) begin
      n_strobe++;
      addr_trace.push_back(mem_addr);
      if (!busy) n_strobe_viol++;
    end
    if (mem_re && mem_we) n_strobe_viol++;
  end

  int n_vec = 0;
  int n_err = 0;
  int wrong_ack = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [15:0] a1, a2, a3;
    a1 = a + 16'd1; a2 = a + 16'd2; a3 = a + 16'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  // Issue one request at a negedge, wait (bounded) for the owner's ack.
  task automatic run_txn(input int op, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] res, output int ntr,
                         output logic merr);
    int   s0;
    logic got;
    logic is_fetch;
    is_fetch = (op == OP_FETCH || op == OP_HALT);
    @(negedge clk);
    s0 = n_strobe;
    instr_en   = (op != OP_HALT);
    instr_req  = is_fetch;
    instr_addr = a;
    data_rd    = (op == OP_LOAD || op == OP_RW);
    data_wr    = (op == OP_STORE || op == OP_RW);
    data_addr  = a;
    data_wdata = wd;
    lat = 0; got = 1'b0; merr = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (is_fetch ? data_ack : instr_ack) wrong_ack++;
      if (is_fetch ? instr_ack : data_ack) begin
        lat = i;
        got = 1'b1;
`ifdef MISALIGN_TRAP_EN
        merr = misalign_err;
`endif
      end
    end
    res = is_fetch ? instr_data : data_rdata;
    ntr = n_strobe - s0;
    instr_req = 1'b0; data_rd = 1'b0; data_wr = 1'b0;
    @(negedge clk);
    chk("ack_pulse_width", {30'd0, instr_ack, data_ack}, 32'd0);
  endtask

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
    int          ntr;
    logic        merr;
  } vec_t;

  vec_t        vecs [12];
  int          lat, ntr, t_d, t_i;
  logic [31:0] res;
  logic        merr;
  logic        saw_ack;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    mem[4] = 8'h55; mem[5] = 8'h66;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;

    //            op        addr          wdata          expected        lat ntr merr
    vecs[0]  = '{OP_FETCH, 32'h0000_0000, 32'h0,         32'hDEADBEEF,   6, 4, 1'b0};
    vecs[1]  = '{OP_STORE, 32'h0000_0010, 32'h12345678,  32'h00000000,   6, 4, 1'b0};
    vecs[2]  = '{OP_LOAD,  32'hABCD_0010, 32'h0,         32'h12345678,   6, 4, 1'b0};
    vecs[3]  = '{OP_HALT,  32'h0000_0000, 32'h0,         32'hFFFFFFFF,   1, 0, 1'b0};
    vecs[4]  = '{OP_FETCH, 32'h0000_0010, 32'h0,         32'h12345678,   6, 4, 1'b0};
    vecs[5]  = '{OP_STORE, 32'h0000_0040, 32'hCAFEF00D,  32'h12345678,   6, 4, 1'b0};
    vecs[6]  = '{OP_LOAD,  32'h0000_0040, 32'h0,         32'hCAFEF00D,   6, 4, 1'b0};
    vecs[7]  = '{OP_RW,    32'h0000_0050, 32'h0BADCAFE,  32'hCAFEF00D,   6, 4, 1'b0};
    vecs[8]  = '{OP_LOAD,  32'h0000_0050, 32'h0,         32'h0BADCAFE,   6, 4, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vecs[9]  = '{OP_LOAD,  32'h0000_0001, 32'h0,         32'h00000000,   1, 0, 1'b1};
    vecs[10] = '{OP_FETCH, 32'h0000_0002, 32'h0,         32'h00000000,   1, 0, 1'b1};
`else
    vecs[9]  = '{OP_LOAD,  32'h0000_0001, 32'h0,         32'hADBEEF55,   6, 4, 1'b0};
    vecs[10] = '{OP_FETCH, 32'h0000_0002, 32'h0,         32'hBEEF5566,   6, 4, 1'b0};
`endif
    vecs[11] = '{OP_LOAD,  32'h0000_0000, 32'h0,         32'hDEADBEEF,   6, 4, 1'b0};

    // Reset state.
    #12;
    chk("rst_strobes_acks_busy", {27'd0, instr_ack, data_ack, busy, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, res, ntr, merr);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_strobes", i), ntr, vecs[i].ntr);
`ifdef MISALIGN_TRAP_EN
      chk($sformatf("v%0d_misalign_err", i), {31'd0, merr}, {31'd0, vecs[i].merr});
`endif
      if ((vecs[i].op == OP_STORE || vecs[i].op == OP_RW) && vecs[i].ntr == 4)
        chk($sformatf("v%0d_mem_word", i), mem_word(vecs[i].addr[15:0]), vecs[i].wdata);
    end

    // Wrap at the top of memory.
    addr_trace.delete();
    run_txn(OP_LOAD, 32'h0000_FFFE, 32'h0, lat, res, ntr, merr);
`ifdef MISALIGN_TRAP_EN
    chk("wrap_latency", lat, 1);
    chk("wrap_result", res, 32'h0);
    chk("wrap_strobes", ntr, 0);
    chk("wrap_misalign_err", {31'd0, merr}, 32'd1);
`else
    chk("wrap_latency", lat, 6);
    chk("wrap_result", res, 32'h1122DEAD);
    chk("wrap_trace_len", addr_trace.size(), 4);
    if (addr_trace.size() == 4)
      chk("wrap_trace", {addr_trace[0], addr_trace[1]}, 32'hFFFEFFFF);
    if (addr_trace.size() == 4)
      chk("wrap_trace_hi", {addr_trace[2], addr_trace[3]}, 32'h00000001);
`endif

    // Simultaneous fetch and load: data wins, fetch follows in the next IDLE.
    @(negedge clk);
    instr_en = 1'b1; instr_req = 1'b1; instr_addr = 32'h0;
    data_rd = 1'b1; data_addr = 32'h10;
    t_d = 0; t_i = 0;
    for (int i = 1; i <= 30 && t_i == 0; i++) begin
      @(negedge clk);
      if (data_ack && t_d == 0) begin t_d = i; data_rd = 1'b0; end
      if (instr_ack) begin t_i = i; instr_req = 1'b0; end
    end
    instr_req = 1'b0; data_rd = 1'b0;
    chk("prio_data_ack_cycle", t_d, 6);
    chk("prio_instr_ack_cycle", t_i, 13);
    chk("prio_data_rdata", data_rdata, 32'h12345678);
    chk("prio_instr_data", instr_data, 32'hDEADBEEF);
    @(negedge clk);

    // Reset in the middle of a store (cnt = 2).
    @(negedge clk);
    data_wr = 1'b1; data_addr = 32'h20; data_wdata = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_store_we_addr", {15'd0, mem_we, mem_addr}, {15'd0, 1'b1, 16'h0022});
    rst_n = 1'b0;
    data_wr = 1'b0;
    #1;
    chk("abort_ctrl_zero", {27'd0, instr_ack, data_ack, busy, mem_re, mem_we}, 32'd0);
    chk("abort_mem_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
    chk("abort_results_zero", instr_data | data_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_ack = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (data_ack || instr_ack) saw_ack = 1'b1;
    end
    chk("abort_no_ack", {31'd0, saw_ack}, 32'd0);
    chk("abort_mem_bytes", mem_word(16'h0020), 32'hAABB0000);

    chk("strobe_rules", n_strobe_viol, 0);
    chk("wrong_port_ack", wrong_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
